// File: rtl/param_bit_counter_bcast.sv
// Parametrised bit counter: samples an ADC-style producer over soc/eoc, counts the selected
// bits of the sample, and broadcasts the count to N consumers on a shared dav_/rfd handshake.
module param_bit_counter_bcast #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 3,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          soc,
  input  logic          eoc,
  input  logic [W-1:0]  x,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  en,
  input  logic [N-1:0]  rfd,
  output logic          dav_,
  output logic [CW-1:0] c
);

  localparam logic [1:0] ModeEven  = 2'b00;
  localparam logic [1:0] ModeOdd   = 2'b01;
  localparam logic [1:0] ModeOnes  = 2'b10;
  localparam logic [1:0] ModeZeros = 2'b11;

  if (W < 2) begin : g_bad_width
    $error("param_bit_counter_bcast: W must be at least 2");
  end
  if (N < 1) begin : g_bad_consumers
    $error("param_bit_counter_bcast: N must be at least 1");
  end
  if ((64'd1 << CW) <= 64'(W)) begin : g_bad_count_width
    $error("param_bit_counter_bcast: CW too narrow to hold W");
  end

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitEoc = 3'd1,
    StCount   = 3'd2,
    StOut     = 3'd3,
    StAck     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          soc_q, soc_d;
  logic          dav_q, dav_d;
  logic [W-1:0]  x_q, x_d;
  logic [1:0]    step_q, step_d;
  logic [N-1:0]  en_q, en_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] c_q, c_d;

  logic [W-1:0]  x_sel;
  logic [1:0]    step_sel;
  logic [W-1:0]  x_shift;
  logic [N-1:0]  rfd_en;

  // Odd-bit mode pre-shifts so that every mode counts from bit 0 upward.
  always_comb begin
    x_sel    = x;
    step_sel = 2'd1;
    case (mode)
      ModeEven: begin
        x_sel    = x;
        step_sel = 2'd2;
      end
      ModeOdd: begin
        x_sel    = x >> 1;
        step_sel = 2'd2;
      end
      ModeOnes: begin
        x_sel    = x;
        step_sel = 2'd1;
      end
      ModeZeros: begin
        x_sel    = ~x;
        step_sel = 2'd1;
      end
      default: begin
        x_sel    = x;
        step_sel = 2'd1;
      end
    endcase
  end

  assign x_shift = x_q >> step_q;
  assign rfd_en  = rfd & en_q;

  always_comb begin
    state_d = state_q;
    soc_d   = soc_q;
    dav_d   = dav_q;
    x_d     = x_q;
    step_d  = step_q;
    en_d    = en_q;
    acc_d   = acc_q;
    c_d     = c_q;

    case (state_q)
      StIdle: begin
        soc_d = 1'b1;
        if (!eoc) begin
          state_d = StWaitEoc;
        end
      end

      StWaitEoc: begin
        soc_d  = 1'b0;
        acc_d  = '0;
        x_d    = x_sel;
        step_d = step_sel;
        en_d   = en;
        if (eoc) begin
          state_d = StCount;
        end
      end

      StCount: begin
        acc_d = acc_q + CW'(x_q[0]);
        x_d   = x_shift;
        // Stop once no selected bits remain; the last bit is folded in on this edge.
        if (x_shift == '0) begin
          c_d     = acc_d;
          state_d = (en_q != '0) ? StOut : StIdle;
        end
      end

      StOut: begin
        dav_d = 1'b0;
        if (rfd_en == '0) begin
          state_d = StAck;
        end
      end

      StAck: begin
        dav_d = 1'b1;
        if (rfd_en == en_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      soc_q   <= 1'b0;
      dav_q   <= 1'b1;
      x_q     <= '0;
      step_q  <= 2'd1;
      en_q    <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      dav_q   <= dav_d;
      x_q     <= x_d;
      step_q  <= step_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  assign soc  = soc_q;
  assign dav_ = dav_q;
  assign c    = c_q;

endmodule
